pc_unit: RTL and testbench

//  Parametrised program-counter unit for the fetch stage: sequential advance, stall hold,

---
 rtl/pc_unit.sv | 135 +++++++++++++
 tb/tb_pc_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: sequential advance, stall, redirect, single-level interrupt entry/return.
// Define PC_RAS_EN to add a circular return-address stack driven by call/ret.
module pc_unit #(
   parameter int               WIDTH     = 32,
   parameter int               STEP      = 1,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32),
   parameter logic [WIDTH-1:0] INT_VEC   = '0,
   parameter int               RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_tgt,
   input  logic             call,
   input  logic             ret,
   input  logic             int_req,
   input  logic             rti,
   output logic [WIDTH-1:0] pc,
   output logic             pc_valid,
   output logic             int_ack,
   output logic [WIDTH-1:0] epc,
   output logic             in_handler,
   output logic             ras_empty,
   output logic             ras_uflow
);

   typedef enum logic {RUN, INT_SAVE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] pc_nxt, epc_nxt, pc_inc, ras_top;
   logic             in_handler_nxt, uflow_nxt, push, pop;

   assign pc_inc = pc + WIDTH'(STEP);

`ifdef PC_RAS_EN
   localparam bit                RAS_ON = 1'b1;
   localparam int                PTR_W  = $clog2(RAS_DEPTH);
   localparam logic [PTR_W:0]    FULL   = (PTR_W+1)'(RAS_DEPTH);

   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0] sp;   // next free slot; top of stack is sp-1
   logic [PTR_W:0]   cnt;

   assign ras_top   = ras_mem[sp - PTR_W'(1)];
   assign ras_empty = (cnt == '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         sp  <= '0;
         cnt <= '0;
      end else if (push) begin
         // A push into a full stack silently drops the oldest entry.
         sp <= sp + PTR_W'(1);
         if (cnt != FULL) cnt <= cnt + (PTR_W+1)'(1);
      end else if (pop) begin
         sp  <= sp - PTR_W'(1);
         cnt <= cnt - (PTR_W+1)'(1);
      end
   end

   // NOTE: storage needs no reset; cnt==0 already marks every entry invalid.
   always_ff @(posedge clk) begin
      if (push && rst) ras_mem[sp] <= pc_inc;
   end
`else
   localparam bit RAS_ON = 1'b0;
   logic unused_ras;

   assign ras_top    = '0;
   assign ras_empty  = 1'b1;
   assign unused_ras = ^{push, pop, RAS_DEPTH[0]};
`endif

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      epc_nxt        = epc;
      in_handler_nxt = in_handler;
      uflow_nxt      = 1'b0;
      push           = 1'b0;
      pop            = 1'b0;
      case (state)
         INT_SAVE: begin
            state_nxt      = RUN;
            pc_nxt         = INT_VEC;
            in_handler_nxt = 1'b1;
         end
         default: begin
            if (int_req && !in_handler && !stall) begin
               state_nxt = INT_SAVE;
               epc_nxt   = pc;
            end else if (rti && in_handler) begin
               pc_nxt         = epc;
               in_handler_nxt = 1'b0;
            end else if (redirect) begin
               pc_nxt = redirect_tgt;
               push   = RAS_ON && call;
            end else if (RAS_ON && ret) begin
               if (ras_empty) begin
                  pc_nxt    = pc_inc;
                  uflow_nxt = 1'b1;
               end else begin
                  pc_nxt = ras_top;
                  pop    = 1'b1;
               end
            end else if (!stall) begin
               pc_nxt = pc_inc;
            end
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update together.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= RUN;
         pc         <= RESET_VEC;
         epc        <= '0;
         in_handler <= 1'b0;
         ras_uflow  <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         epc        <= epc_nxt;
         in_handler <= in_handler_nxt;
         ras_uflow  <= uflow_nxt;
      end
   end

   assign pc_valid = (state == RUN);
   assign int_ack  = (state == INT_SAVE);

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a queue-based reference model predicts every cycle's outputs,
// and an independent monitor compares them on the falling edge. Covers both PC_RAS_EN builds.
module tb_pc_unit;

   localparam logic [31:0] RESET_VEC = 32'd32;
   localparam logic [31:0] INT_VEC   = 32'd0;
   localparam int          STEP      = 1;
   localparam int          DEPTH     = 4;
`ifdef PC_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0, stall = 1'b0, redirect = 1'b0, call = 1'b0;
   logic        ret = 1'b0, int_req = 1'b0, rti = 1'b0;
   logic [31:0] redirect_tgt = '0;
   logic [31:0] pc, epc;
   logic        pc_valid, int_ack, in_handler, ras_empty, ras_uflow;

   typedef struct packed {
      logic [31:0] pc;
      logic        pc_valid;
      logic        int_ack;
      logic [31:0] epc;
      logic        in_handler;
      logic        ras_empty;
      logic        ras_uflow;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model state
   logic [31:0] m_pc = RESET_VEC, m_epc = '0;
   logic        m_inh = 1'b0, m_save = 1'b0;
   logic [31:0] m_ras[$];

   pc_unit #(
      .WIDTH(32), .STEP(STEP), .RESET_VEC(RESET_VEC), .INT_VEC(INT_VEC), .RAS_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_tgt(redirect_tgt),
      .call(call), .ret(ret), .int_req(int_req), .rti(rti), .pc(pc), .pc_valid(pc_valid),
      .int_ack(int_ack), .epc(epc), .in_handler(in_handler), .ras_empty(ras_empty),
      .ras_uflow(ras_uflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Apply one cycle of inputs, predict the post-edge outputs, then advance past the edge.
   task automatic step(input logic r, input logic st, input logic rd, input logic [31:0] tg,
                       input logic cl, input logic rt, input logic ir, input logic ri);
      exp_t e;
      logic uf;
      rst = r; stall = st; redirect = rd; redirect_tgt = tg;
      call = cl; ret = rt; int_req = ir; rti = ri;
      uf = 1'b0;
      if (!r) begin
         m_pc = RESET_VEC; m_epc = '0; m_inh = 1'b0; m_save = 1'b0;
         m_ras.delete();
      end else if (m_save) begin
         m_pc = INT_VEC; m_inh = 1'b1; m_save = 1'b0;
      end else if (ir && !m_inh && !st) begin
         m_epc = m_pc; m_save = 1'b1;
      end else if (ri && m_inh) begin
         m_pc = m_epc; m_inh = 1'b0;
      end else if (rd) begin
         if (RAS_ON && cl) begin
            m_ras.push_back(m_pc + STEP);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
         end
         m_pc = tg;
      end else if (RAS_ON && rt) begin
         if (m_ras.size() == 0) begin
            m_pc = m_pc + STEP;
            uf   = 1'b1;
         end else begin
            m_pc = m_ras.pop_back();
         end
      end else if (!st) begin
         m_pc = m_pc + STEP;
      end
      e.pc         = m_pc;
      e.pc_valid   = !m_save;
      e.int_ack    = m_save;
      e.epc        = m_epc;
      e.in_handler = m_inh;
      e.ras_empty  = RAS_ON ? (m_ras.size() == 0) : 1'b1;
      e.ras_uflow  = uf;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic jump(input logic [31:0] tg, input logic cl);
      step(1, 0, 1, tg, cl, 0, 0, 0);
   endtask

   // Monitor: every cycle is an output cycle; compare on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pc",         pc,         e.pc);
            check("pc_valid",   pc_valid,   e.pc_valid);
            check("int_ack",    int_ack,    e.int_ack);
            check("epc",        epc,        e.epc);
            check("in_handler", in_handler, e.in_handler);
            check("ras_empty",  ras_empty,  e.ras_empty);
            check("ras_uflow",  ras_uflow,  e.ras_uflow);
         end
      end
   end

   initial begin
      // Reset then free-running advance
      step(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) idle();
      // Stall hold, redirect overrides stall
      jump(32'd40, 0);
      repeat (3) step(1, 1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 1, 32'd1234, 0, 0, 0, 0);
      // Interrupt entry, held request does not re-enter, rti returns
      jump(32'd100, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0);
      repeat (3) step(1, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 1, 1);
      step(1, 0, 0, 0, 0, 0, 0, 1);   // rti outside handler is ignored
      // Stall defers an interrupt
      repeat (2) step(1, 1, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0);
      idle();
      step(1, 0, 1, 32'd555, 0, 0, 0, 1);  // rti beats redirect
      // Address wrap
      jump(32'hFFFF_FFFF, 0);
      idle();
      idle();
      // Reset during INT_SAVE and on the accepting edge
      step(1, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      jump(32'd77, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      // Call/return sequence with underflow
      jump(32'd10, 0);
      jump(32'd50, 1);
      jump(32'd80, 1);
      repeat (3) step(1, 0, 0, 0, 0, 1, 0, 0);
      idle();
      // call and ret together: redirect wins
      step(1, 0, 1, 32'd90, 1, 1, 0, 0);
      step(1, 1, 0, 0, 0, 1, 0, 0);   // ret beats stall
      // Five nested calls overflow a 4-deep stack
      for (int i = 1; i <= 5; i++) jump(32'd100 * i + 32'd100, 1);
      repeat (5) step(1, 0, 0, 0, 0, 1, 0, 0);
      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(39) != 0), ($urandom_range(3) == 0), ($urandom_range(4) == 0),
              $urandom, $urandom_range(1) == 1, ($urandom_range(5) == 0),
              ($urandom_range(7) == 0), ($urandom_range(7) == 0));
      end
      idle();
      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
